// File: rtl/axi_ic_pkg.sv
// Shared types for the AW interconnect: QoS type, AW FSM states, W-route entry.
// No logic of its own; rr_qos_pick is a combinational arbitration helper.
// Backpressure: not applicable.
package axi_ic_pkg;

    localparam int MAX_M      = 16;
    localparam int MAX_M_W    = 4;
    localparam int WQ_FIELD_W = 8;

    typedef logic [3:0] qos_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        DECERR = 2'd2
    } aw_state_e;

    typedef struct packed {
        logic [WQ_FIELD_W-1:0] master;
        logic [WQ_FIELD_W-1:0] slave;
        logic [WQ_FIELD_W-1:0] len;
        logic                  decerr;
    } wq_entry_t;

    // Scan cyclically from ptr; a later candidate only replaces the current
    // winner on strictly higher qos, so ties stay with the earliest one.
    function automatic int rr_qos_pick(input logic [MAX_M-1:0] valid,
                                       input qos_t [MAX_M-1:0] qos,
                                       input int               ptr,
                                       input int               n,
                                       input bit               qos_en);
        int               best;
        qos_t             best_q;
        logic [MAX_M_W-1:0] idx;
        best   = -1;
        best_q = '0;
        idx    = '0;
        for (int k = 0; k < MAX_M; k++) begin
            if (k < n) begin
                idx = MAX_M_W'((ptr + k) % n);
                if (valid[idx] && (best < 0 || (qos_en && qos[idx] > best_q))) begin
                    best   = int'(idx);
                    best_q = qos[idx];
                end
            end
        end
        return (best < 0) ? 0 : best;
    endfunction

endpackage

// File: rtl/axi_aw_qos_router_if.sv
// AW channel bundle: master-side (s_*) and slave-side (m_*) arrays.
// No latency; pure wiring.
// Backpressure: s_awready / m_awready handshakes.
interface axi_aw_qos_router_if #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8
);
    import axi_ic_pkg::*;

    logic [NUM_MASTERS-1:0][ADDR_W-1:0] s_awaddr;
    logic [NUM_MASTERS-1:0][LEN_W-1:0]  s_awlen;
    logic [NUM_MASTERS-1:0][2:0]        s_awsize;
    logic [NUM_MASTERS-1:0][1:0]        s_awburst;
    qos_t [NUM_MASTERS-1:0]             s_awqos;
    logic [NUM_MASTERS-1:0]             s_awvalid;
    logic [NUM_MASTERS-1:0]             s_awready;

    logic [NUM_SLAVES-1:0][ADDR_W-1:0]  m_awaddr;
    logic [NUM_SLAVES-1:0][LEN_W-1:0]   m_awlen;
    logic [NUM_SLAVES-1:0][2:0]         m_awsize;
    logic [NUM_SLAVES-1:0][1:0]         m_awburst;
    qos_t [NUM_SLAVES-1:0]              m_awqos;
    logic [NUM_SLAVES-1:0]              m_awvalid;
    logic [NUM_SLAVES-1:0]              m_awready;

    // Environment side: drives master requests and slave readies.
    modport master (
        output s_awaddr, s_awlen, s_awsize, s_awburst, s_awqos, s_awvalid,
        input  s_awready,
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awqos, m_awvalid,
        output m_awready
    );

    // Router side.
    modport slave (
        input  s_awaddr, s_awlen, s_awsize, s_awburst, s_awqos, s_awvalid,
        output s_awready,
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awqos, m_awvalid,
        input  m_awready
    );

endinterface

// File: rtl/aw_route_fifo.sv
// W-route queue: sync FIFO of wq_entry_t with count/full/empty.
// Latency: push visible at head one cycle later; simultaneous push/pop allowed.
// Backpressure: caller must not push when full nor pop when empty.
module aw_route_fifo
    import axi_ic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_vld,
    input  wq_entry_t                push_dat,
    input  logic                     pop_vld,
    output wq_entry_t                pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/axi_aw_qos_router.sv
// N:M AW router with RR / QoS arbitration, address decode and W-route queue.
// Latency: grant registered in IDLE, slave valid 1 cycle after master valid.
// Backpressure: s_awready follows m_awready of the decoded slave; no grant while queue full.
module axi_aw_qos_router
    import axi_ic_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int SEL_W       = 2,
    parameter int QOS_MODE    = 1,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    axi_aw_qos_router_if.slave             aw,
    output logic                           aw_access_grant,
    output logic [$clog2(NUM_MASTERS)-1:0] aw_granted_master,
    output logic [SEL_W-1:0]               aw_selected_slave,
    input  logic                           w_done,
    output logic                           wq_valid,
    output logic [$clog2(NUM_MASTERS)-1:0] wq_master,
    output logic [SEL_W-1:0]               wq_slave,
    output logic [LEN_W-1:0]               wq_len,
    output logic                           wq_decerr,
    output logic                           queue_full,
    output logic [3:0]                     num_compl_bursts,
    output logic                           pop_underflow
);

    localparam int MST_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [SEL_W:0] NS_LIM = (SEL_W+1)'(NUM_SLAVES);

    aw_state_e        state, state_n;
    logic [MST_W-1:0] g_q, rr_ptr, pick;
    logic [SEL_W-1:0] sel_q, pick_sel;

    logic [MAX_M-1:0] cand_vld;
    qos_t [MAX_M-1:0] cand_qos;

    logic              g_vld, sel_rdy;
    logic [ADDR_W-1:0] g_addr;
    logic [LEN_W-1:0]  g_len;
    logic [2:0]        g_size;
    logic [1:0]        g_burst;
    qos_t              g_qos;

    logic             push, pop;
    wq_entry_t        push_dat, head;
    logic [CNT_W-1:0] wq_count;
    logic             wq_full, wq_empty;
    logic             unused_head;

    always_comb begin
        cand_vld = '0;
        cand_qos = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand_vld[i] = aw.s_awvalid[i];
            cand_qos[i] = aw.s_awqos[i];
        end
    end

    assign pick = MST_W'(rr_qos_pick(cand_vld, cand_qos, int'(rr_ptr), NUM_MASTERS, QOS_MODE != 0));

    // Muxes: decode address of the arbitration winner, payload of the held grant.
    always_comb begin
        pick_sel = '0;
        g_vld    = 1'b0;
        g_addr   = '0;
        g_len    = '0;
        g_size   = '0;
        g_burst  = '0;
        g_qos    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick == MST_W'(i)) pick_sel = aw.s_awaddr[i][ADDR_W-1 -: SEL_W];
            if (g_q == MST_W'(i)) begin
                g_vld   = aw.s_awvalid[i];
                g_addr  = aw.s_awaddr[i];
                g_len   = aw.s_awlen[i];
                g_size  = aw.s_awsize[i];
                g_burst = aw.s_awburst[i];
                g_qos   = aw.s_awqos[i];
            end
        end
        sel_rdy = 1'b0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (sel_q == SEL_W'(s)) sel_rdy = aw.m_awready[s];
        end
    end

    always_comb begin
        state_n      = state;
        push         = 1'b0;
        aw.s_awready = '0;
        aw.m_awvalid = '0;
        aw.m_awaddr  = '0;
        aw.m_awlen   = '0;
        aw.m_awsize  = '0;
        aw.m_awburst = '0;
        aw.m_awqos   = '0;
        case (state)
            IDLE: begin
                if (|aw.s_awvalid && (wq_count < CNT_W'(QUEUE_DEPTH)))
                    state_n = ({1'b0, pick_sel} >= NS_LIM) ? DECERR : SEND;
            end
            SEND: begin
                for (int s = 0; s < NUM_SLAVES; s++) begin
                    if (sel_q == SEL_W'(s)) begin
                        aw.m_awvalid[s] = g_vld;
                        aw.m_awaddr[s]  = g_addr;
                        aw.m_awlen[s]   = g_len;
                        aw.m_awsize[s]  = g_size;
                        aw.m_awburst[s] = g_burst;
                        aw.m_awqos[s]   = g_qos;
                    end
                end
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (g_q == MST_W'(i)) aw.s_awready[i] = sel_rdy;
                end
                if (g_vld && sel_rdy) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end
            end
            DECERR: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (g_q == MST_W'(i)) aw.s_awready[i] = 1'b1;
                end
                push    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            g_q    <= '0;
            sel_q  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n != IDLE) begin
                g_q   <= pick;
                sel_q <= pick_sel;
            end
            if (push) rr_ptr <= (g_q == MST_W'(NUM_MASTERS-1)) ? '0 : g_q + MST_W'(1);
        end
    end

    assign push_dat = '{master: WQ_FIELD_W'(g_q),
                        slave:  WQ_FIELD_W'(sel_q),
                        len:    WQ_FIELD_W'(g_len),
                        decerr: (state == DECERR)};

    assign pop = w_done && !wq_empty;

    aw_route_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_wq (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_vld  (pop),
        .pop_dat  (head),
        .count    (wq_count),
        .full     (wq_full),
        .empty    (wq_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_compl_bursts <= '0;
            pop_underflow    <= 1'b0;
        end else begin
            if (pop) num_compl_bursts <= num_compl_bursts + 4'd1;
            if (w_done && wq_empty) pop_underflow <= 1'b1;
        end
    end

    assign aw_access_grant   = (state != IDLE);
    assign aw_granted_master = g_q;
    assign aw_selected_slave = sel_q;
    assign wq_valid          = !wq_empty;
    assign wq_master         = head.master[MST_W-1:0];
    assign wq_slave          = head.slave[SEL_W-1:0];
    assign wq_len            = head.len[LEN_W-1:0];
    assign wq_decerr         = head.decerr;
    assign queue_full        = wq_full;
    assign unused_head       = ^head;

endmodule

// File: tb/tb_axi_aw_qos_router.sv
// Directed bench: dut_a (3 slaves, QoS mode) and dut_b (4 slaves, round-robin).
module tb_axi_aw_qos_router;
    import axi_ic_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    axi_aw_qos_router_if #(.NUM_MASTERS(4), .NUM_SLAVES(3), .ADDR_W(32), .LEN_W(8)) ifa ();
    axi_aw_qos_router_if #(.NUM_MASTERS(4), .NUM_SLAVES(4), .ADDR_W(32), .LEN_W(8)) ifb ();

    logic       a_grant, a_wq_valid, a_wq_decerr, a_full, a_unf, a_w_done;
    logic [1:0] a_gm, a_sel, a_wq_master, a_wq_slave;
    logic [7:0] a_wq_len;
    logic [3:0] a_ncb;

    logic       b_grant, b_wq_valid, b_wq_decerr, b_full, b_unf, b_w_done;
    logic [1:0] b_gm, b_sel, b_wq_master, b_wq_slave;
    logic [7:0] b_wq_len;
    logic [3:0] b_ncb;

    axi_aw_qos_router #(
        .NUM_MASTERS(4), .NUM_SLAVES(3), .ADDR_W(32), .LEN_W(8),
        .SEL_W(2), .QOS_MODE(1), .QUEUE_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .aw(ifa.slave),
        .aw_access_grant(a_grant), .aw_granted_master(a_gm), .aw_selected_slave(a_sel),
        .w_done(a_w_done), .wq_valid(a_wq_valid), .wq_master(a_wq_master),
        .wq_slave(a_wq_slave), .wq_len(a_wq_len), .wq_decerr(a_wq_decerr),
        .queue_full(a_full), .num_compl_bursts(a_ncb), .pop_underflow(a_unf)
    );

    axi_aw_qos_router #(
        .NUM_MASTERS(4), .NUM_SLAVES(4), .ADDR_W(32), .LEN_W(8),
        .SEL_W(2), .QOS_MODE(0), .QUEUE_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .aw(ifb.slave),
        .aw_access_grant(b_grant), .aw_granted_master(b_gm), .aw_selected_slave(b_sel),
        .w_done(b_w_done), .wq_valid(b_wq_valid), .wq_master(b_wq_master),
        .wq_slave(b_wq_slave), .wq_len(b_wq_len), .wq_decerr(b_wq_decerr),
        .queue_full(b_full), .num_compl_bursts(b_ncb), .pop_underflow(b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ifa.s_awaddr = '0; ifa.s_awlen = '0; ifa.s_awsize = '0;
        ifa.s_awburst = '0; ifa.s_awqos = '0; ifa.s_awvalid = '0;
        ifb.s_awaddr = '0; ifb.s_awlen = '0; ifb.s_awsize = '0;
        ifb.s_awburst = '0; ifb.s_awqos = '0; ifb.s_awvalid = '0;
        ifa.m_awready = 3'b111;
        ifb.m_awready = 4'b1111;
        a_w_done = 1'b0;
        b_w_done = 1'b0;
    endtask

    // Ends on a negedge with reset released; caller drives the first cycle there.
    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // ---------------- reset state + single write (dut_a) ----------------
        do_reset();
        #1;
        chk("rst_grant", a_grant, 1'b0);
        chk("rst_m_awvalid", ifa.m_awvalid, 3'b000);
        chk("rst_s_awready", ifa.s_awready, 4'b0000);
        chk("rst_wq_valid", a_wq_valid, 1'b0);
        chk("rst_queue_full", a_full, 1'b0);
        chk("rst_ncb", a_ncb, 4'd0);
        chk("rst_underflow", a_unf, 1'b0);
        chk("rst_m_awaddr", ifa.m_awaddr, 96'h0);
        ifa.s_awaddr[1] = 32'h4000_0000;
        ifa.s_awlen[1]  = 8'd3;
        ifa.s_awsize[1] = 3'd2;
        ifa.s_awburst[1] = 2'd1;
        ifa.s_awvalid   = 4'b0010;
        #1;
        chk("single_idle_no_valid", ifa.m_awvalid, 3'b000);
        chk("single_idle_no_ready", ifa.s_awready, 4'b0000);
        @(negedge clk); #1;
        chk("single_m_awvalid", ifa.m_awvalid, 3'b010);
        chk("single_m_awaddr1", ifa.m_awaddr[1], 32'h4000_0000);
        chk("single_m_awlen1", ifa.m_awlen[1], 8'd3);
        chk("single_m_awburst1", ifa.m_awburst[1], 2'd1);
        chk("single_s_awready", ifa.s_awready, 4'b0010);
        chk("single_granted", a_gm, 2'd1);
        chk("single_slave", a_sel, 2'd1);
        chk("single_grant", a_grant, 1'b1);
        @(negedge clk);
        ifa.s_awvalid = 4'b0000;
        a_w_done = 1'b1;
        #1;
        chk("single_wq_valid", a_wq_valid, 1'b1);
        chk("single_wq_head", {a_wq_master, a_wq_slave, a_wq_len, a_wq_decerr}, {2'd1, 2'd1, 8'd3, 1'b0});
        chk("single_back_idle", a_grant, 1'b0);
        @(negedge clk);
        a_w_done = 1'b0;
        #1;
        chk("single_popped", a_wq_valid, 1'b0);
        chk("single_ncb", a_ncb, 4'd1);
        chk("single_no_underflow", a_unf, 1'b0);

        // ---------------- QoS priority (dut_a) ----------------
        do_reset();
        ifa.s_awaddr[0] = 32'h0000_0100; ifa.s_awqos[0] = 4'd2; ifa.s_awlen[0] = 8'd0;
        ifa.s_awaddr[2] = 32'h0000_0200; ifa.s_awqos[2] = 4'd9; ifa.s_awlen[2] = 8'd2;
        ifa.s_awaddr[3] = 32'h0000_0300; ifa.s_awqos[3] = 4'd9; ifa.s_awlen[3] = 8'd3;
        ifa.s_awvalid = 4'b1101;
        #1;
        chk("qos_idle", a_grant, 1'b0);
        @(negedge clk); #1;
        chk("qos_first_m2", a_gm, 2'd2);
        chk("qos_first_ready", ifa.s_awready, 4'b0100);
        chk("qos_first_slave0", ifa.m_awvalid, 3'b001);
        chk("qos_first_qos", ifa.m_awqos[0], 4'd9);
        @(negedge clk);
        ifa.s_awvalid = 4'b1001;
        #1;
        chk("qos_bubble", a_grant, 1'b0);
        @(negedge clk); #1;
        chk("qos_second_m3", a_gm, 2'd3);
        @(negedge clk);
        ifa.s_awvalid = 4'b0001;
        #1;
        chk("qos_bubble2", a_grant, 1'b0);
        @(negedge clk); #1;
        chk("qos_third_m0", a_gm, 2'd0);
        chk("qos_third_grant", a_grant, 1'b1);
        @(negedge clk);
        ifa.s_awvalid = 4'b0000;
        a_w_done = 1'b1;
        #1;
        chk("qos_q_head0", {a_wq_master, a_wq_len}, {2'd2, 8'd2});
        chk("qos_q_not_full", a_full, 1'b0);
        @(negedge clk); #1;
        chk("qos_q_head1", a_wq_master, 2'd3);
        chk("qos_ncb1", a_ncb, 4'd1);
        @(negedge clk); #1;
        chk("qos_q_head2", {a_wq_master, a_wq_len}, {2'd0, 8'd0});
        @(negedge clk);
        a_w_done = 1'b0;
        #1;
        chk("qos_q_empty", a_wq_valid, 1'b0);
        chk("qos_ncb3", a_ncb, 4'd3);

        // ---------------- RR fairness + queue full (dut_b) ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ifb.s_awaddr[i] = 32'(i) << 30;
            ifb.s_awlen[i]  = 8'(i + 4);
            ifb.s_awqos[i]  = 4'd5;
        end
        ifb.s_awvalid = 4'b1111;
        @(negedge clk); #1;
        chk("rr_g0", {b_gm, b_sel}, {2'd0, 2'd0});
        chk("rr_g0_valid", ifb.m_awvalid, 4'b0001);
        @(negedge clk);
        @(negedge clk); #1;
        chk("rr_g1", {b_gm, b_sel}, {2'd1, 2'd1});
        @(negedge clk);
        @(negedge clk); #1;
        chk("rr_g2", {b_gm, b_sel}, {2'd2, 2'd2});
        @(negedge clk);
        @(negedge clk); #1;
        chk("rr_g3", {b_gm, b_sel}, {2'd3, 2'd3});
        chk("rr_g3_valid", ifb.m_awvalid, 4'b1000);
        @(negedge clk); #1;
        chk("full_flag", b_full, 1'b1);
        chk("full_head", {b_wq_master, b_wq_slave, b_wq_len}, {2'd0, 2'd0, 8'd4});
        chk("full_no_grant_a", b_grant, 1'b0);
        @(negedge clk); #1;
        chk("full_no_grant_b", b_grant, 1'b0);
        @(negedge clk);
        b_w_done = 1'b1;
        #1;
        chk("full_no_grant_c", b_grant, 1'b0);
        @(negedge clk);
        b_w_done = 1'b0;
        #1;
        chk("pop_not_forwarded", b_grant, 1'b0);
        chk("full_ncb1", b_ncb, 4'd1);
        chk("full_cleared", b_full, 1'b0);
        chk("full_head_next", b_wq_master, 2'd1);
        @(negedge clk); #1;
        chk("rr_g0_again", {b_grant, b_gm}, {1'b1, 2'd0});
        ifb.s_awvalid = 4'b0000;

        // ---------------- decode error + underflow (dut_a) ----------------
        do_reset();
        ifa.s_awaddr[1] = 32'hC000_0000;
        ifa.s_awlen[1]  = 8'd5;
        ifa.s_awvalid   = 4'b0010;
        @(negedge clk); #1;
        chk("decerr_no_valid", ifa.m_awvalid, 3'b000);
        chk("decerr_ready", ifa.s_awready, 4'b0010);
        chk("decerr_grant", {a_grant, a_sel}, {1'b1, 2'd3});
        @(negedge clk);
        ifa.s_awvalid = 4'b0000;
        a_w_done = 1'b1;
        #1;
        chk("decerr_ready_one_cycle", ifa.s_awready, 4'b0000);
        chk("decerr_head", {a_wq_valid, a_wq_master, a_wq_slave, a_wq_len, a_wq_decerr},
            {1'b1, 2'd1, 2'd3, 8'd5, 1'b1});
        @(negedge clk); #1;
        chk("decerr_popped", {a_wq_valid, a_unf, a_ncb}, {1'b0, 1'b0, 4'd1});
        @(negedge clk);
        a_w_done = 1'b0;
        #1;
        chk("underflow_set", a_unf, 1'b1);
        chk("underflow_ncb_hold", a_ncb, 4'd1);

        // ---------------- reset mid-SEND (dut_a) ----------------
        @(negedge clk);
        ifa.m_awready   = 3'b000;
        ifa.s_awaddr[0] = 32'h8000_0000;
        ifa.s_awvalid   = 4'b0001;
        @(negedge clk); #1;
        chk("midsend_valid", ifa.m_awvalid, 3'b100);
        chk("midsend_stall", ifa.s_awready, 4'b0000);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midsend_async_drop", ifa.m_awvalid, 3'b000);
        chk("midsend_async_grant", a_grant, 1'b0);
        ifa.s_awvalid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("after_rst_state", {a_wq_valid, a_ncb, a_unf, a_grant}, {1'b0, 4'd0, 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
